// File: rtl/spi_reg_ctrl.sv
// SPI-framed register file: command byte selects read/write and start address, data bytes
// stream into or out of a small register file that the host can also read and write.
`timescale 1ns / 1ps
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter bit          AUTO_INC = 1'b1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              byte_rdy,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [7:0]        host_rd_data,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [7:0]        host_wr_data,
  output logic              host_wr_ack,
  output logic              busy,
  output logic              cmd_err,
  input  logic              err_clr
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDrain} state_e;

  state_e              state_q;
  logic [7:0]          regs_q [NumRegs];
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [7:0]          tx_byte_q;
  logic                tx_load_q;
  logic                cmd_err_q;
  logic                armed_q;
  logic                ss_meta_q;
  logic                ss_sync_q;
  logic [1:0]          sync_vld_q;

  logic [ADDR_W-1:0]   cmd_addr;
  logic                cmd_bad;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                spi_we;

  assign cmd_addr = rx_byte[ADDR_W-1:0];
  assign cmd_bad  = |(rx_byte[6:0] >> ADDR_W);
  assign addr_nxt = AUTO_INC ? addr_q + 1'b1 : addr_q;
  assign spi_we   = (state_q == StData) && !rw_q && byte_rdy;

  assign host_wr_ack  = host_wr_en && !spi_we;
  assign host_rd_data = regs_q[host_rd_addr];
  assign tx_byte      = tx_byte_q;
  assign tx_load      = tx_load_q;
  assign busy         = (state_q != StIdle);
  assign cmd_err      = cmd_err_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ss_meta_q  <= 1'b0;
      ss_sync_q  <= 1'b0;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= StIdle;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_load_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      ss_meta_q  <= ss;
      ss_sync_q  <= ss_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      tx_load_q  <= 1'b0;
      // Only a genuine low sample of the pad arms; the reset value of the sync chain does not.
      if (sync_vld_q[1] && !ss_sync_q) armed_q <= 1'b1;
      if (err_clr) cmd_err_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (armed_q && ss_sync_q) begin
            state_q   <= StCmd;
            tx_load_q <= 1'b1;
            tx_byte_q <= {cmd_err_q, 7'b0};
          end
        end
        StCmd: begin
          if (byte_rdy) begin
            if (cmd_bad) begin
              cmd_err_q <= 1'b1;
              state_q   <= StDrain;
              tx_load_q <= 1'b1;
              tx_byte_q <= 8'hFF;
            end else begin
              rw_q    <= rx_byte[7];
              addr_q  <= cmd_addr;
              state_q <= StData;
              if (rx_byte[7]) begin
                tx_load_q <= 1'b1;
                tx_byte_q <= regs_q[cmd_addr];
              end
            end
          end
        end
        StData: begin
          if (byte_rdy) begin
            addr_q <= addr_nxt;
            if (rw_q) begin
              tx_load_q <= 1'b1;
              tx_byte_q <= regs_q[addr_nxt];
            end
          end
        end
        StDrain: ;
        default: state_q <= StIdle;
      endcase

      // A byte landing with the frame end is still processed above; only the state is overridden.
      if (state_q != StIdle && !ss_sync_q) state_q <= StIdle;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) regs_q[i] <= 8'h00;
    end else if (spi_we) begin
      regs_q[addr_q] <= rx_byte;
    end else if (host_wr_en) begin
      regs_q[host_wr_addr] <= host_wr_data;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed plus randomized frames against a register-array model of the SPI register controller.
`timescale 1ns / 1ps
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst, ss, byte_rdy, host_wr_en, err_clr;
  logic [7:0] rx_byte, host_wr_data, tx_byte, host_rd_data;
  logic [2:0] host_rd_addr, host_wr_addr;
  logic       tx_load, host_wr_ack, busy, cmd_err;

  logic [7:0] mregs [8];
  logic       merr;
  logic [7:0] mtx;
  logic [7:0] fd [4];
  int         vectors = 0;
  int         miscompares = 0;

  always #10 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(3), .AUTO_INC(1'b1)) dut (
    .sys_clk      (clk),
    .rst          (rst),
    .ss           (ss),
    .byte_rdy     (byte_rdy),
    .rx_byte      (rx_byte),
    .tx_byte      (tx_byte),
    .tx_load      (tx_load),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ack  (host_wr_ack),
    .busy         (busy),
    .cmd_err      (cmd_err),
    .err_clr      (err_clr)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      host_rd_addr = 3'(i);
      #1;
      chk(tag, host_rd_data, mregs[i]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_rdy = 1'b1;
    rx_byte  = b;
    cyc();
    byte_rdy = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic frame_open();
    ss = 1'b1;
    repeat (3) cyc();
    mtx = {merr, 7'b0};
    chk("open_busy", {7'b0, busy}, 8'h01);
    chk("open_ld", {7'b0, tx_load}, 8'h01);
    chk("open_tx", tx_byte, mtx);
    cyc();
    chk("open_ld_drop", {7'b0, tx_load}, 8'h00);
  endtask

  task automatic frame_close();
    ss = 1'b0;
    repeat (3) cyc();
    chk("close_busy", {7'b0, busy}, 8'h00);
    cyc();
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    #1;
    chk("host_ack", {7'b0, host_wr_ack}, 8'h01);
    cyc();
    host_wr_en = 1'b0;
    mregs[a]   = d;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    merr    = 1'b0;
    chk("err_clr", {7'b0, cmd_err}, 8'h00);
  endtask

  // Reference behaviour: command decode, then per-byte write or read with wrapping address.
  task automatic do_frame(input logic [7:0] cmd, input int n);
    bit   bad;
    bit   rw;
    int   a;
    logic exp_ld;
    frame_open();
    send_byte(cmd);
    bad = (cmd[6:3] != 4'd0);
    rw  = cmd[7];
    a   = int'(cmd[2:0]);
    if (bad) begin
      merr = 1'b1; mtx = 8'hFF; exp_ld = 1'b1;
    end else if (rw) begin
      mtx = mregs[a]; exp_ld = 1'b1;
    end else begin
      exp_ld = 1'b0;
    end
    chk("cmd_ld", {7'b0, tx_load}, {7'b0, exp_ld});
    chk("cmd_tx", tx_byte, mtx);
    chk("cmd_err", {7'b0, cmd_err}, {7'b0, merr});
    cyc();
    chk("cmd_ld_drop", {7'b0, tx_load}, 8'h00);
    for (int i = 0; i < n; i++) begin
      send_byte(fd[i]);
      exp_ld = 1'b0;
      if (!bad) begin
        if (!rw) mregs[a] = fd[i];
        a = (a + 1) % 8;
        if (rw) begin
          mtx = mregs[a]; exp_ld = 1'b1;
        end
      end
      chk("data_ld", {7'b0, tx_load}, {7'b0, exp_ld});
      chk("data_tx", tx_byte, mtx);
      cyc();
      chk("data_ld_drop", {7'b0, tx_load}, 8'h00);
    end
    frame_close();
    sweep("regs_after_frame");
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ss = 1'b0; byte_rdy = 1'b0; rx_byte = 8'h00; err_clr = 1'b0;
    host_wr_en = 1'b0; host_wr_addr = 3'd0; host_wr_data = 8'h00; host_rd_addr = 3'd0;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    merr = 1'b0;
    mtx  = 8'h00;

    repeat (2) cyc();
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_ld", {7'b0, tx_load}, 8'h00);
    chk("rst_tx", tx_byte, 8'h00);
    chk("rst_err", {7'b0, cmd_err}, 8'h00);
    sweep("rst_regs");
    rst = 1'b0;
    repeat (5) cyc();

    // Write frame
    fd[0] = 8'hAA; fd[1] = 8'hBB;
    do_frame(8'h02, 2);
    host_rd_addr = 3'd3;
    #1;
    chk("wr_frame_reg3", host_rd_data, 8'hBB);
    chk("wr_frame_err", {7'b0, cmd_err}, 8'h00);

    // Read with address wrap 7 -> 0
    host_wr(3'd7, 8'h11);
    host_wr(3'd0, 8'h22);
    fd[0] = 8'h00;
    do_frame(8'h87, 1);

    // Bad command drains the frame
    fd[0] = 8'h99; fd[1] = 8'h77; fd[2] = 8'h5A;
    do_frame(8'h48, 3);
    chk("bad_err", {7'b0, cmd_err}, 8'h01);
    clear_err();

    // Host/SPI collision on reg1
    frame_open();
    send_byte(8'h01);
    cyc();
    host_wr_en = 1'b1; host_wr_addr = 3'd1; host_wr_data = 8'h55;
    byte_rdy = 1'b1; rx_byte = 8'h66;
    #1;
    chk("coll_ack_low", {7'b0, host_wr_ack}, 8'h00);
    cyc();
    byte_rdy = 1'b0;
    #1;
    chk("coll_ack_high", {7'b0, host_wr_ack}, 8'h01);
    cyc();
    host_wr_en = 1'b0;
    mregs[1] = 8'h55;
    frame_close();
    sweep("coll_regs");

    // Byte arriving in the same cycle the synchronized select falls
    frame_open();
    send_byte(8'h04);
    cyc();
    ss = 1'b0;
    repeat (2) cyc();
    byte_rdy = 1'b1; rx_byte = 8'h3C;
    cyc();
    byte_rdy = 1'b0;
    chk("late_byte_idle", {7'b0, busy}, 8'h00);
    mregs[4] = 8'h3C;
    repeat (2) cyc();
    sweep("late_byte_regs");

    // Randomized frames and host traffic
    for (int f = 0; f < 24; f++) begin
      logic [7:0] c;
      int         n;
      c = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        if (c[6:3] == 4'd0) c[5] = 1'b1;
      end else begin
        c[6:3] = 4'd0;
      end
      n = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) fd[i] = 8'($urandom);
      do_frame(c, n);
      if ($urandom_range(0, 2) == 0) host_wr(3'($urandom), 8'($urandom));
      if (merr && $urandom_range(0, 1) == 0) clear_err();
    end

    // Reset while the select is held high: no frame until it toggles
    ss  = 1'b1;
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    merr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("held_ss_busy", {7'b0, busy}, 8'h00);
      chk("held_ss_ld", {7'b0, tx_load}, 8'h00);
    end
    sweep("held_ss_regs");
    ss = 1'b0;
    repeat (4) cyc();
    fd[0] = 8'hC3; fd[1] = 8'h96;
    do_frame(8'h06, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
